// File: rtl/cdb_pkg.sv
// Shared constants and types for the Common Data Bus arbiter.
// The round-robin build is selected by defining CDB_RR_EN.
package cdb_pkg;

    localparam int TAG_W  = 8;
    localparam int DATA_W = 16;

    localparam logic [TAG_W-1:0] TAG_NONE = '0;

    localparam int REQ_ADD = 0;
    localparam int REQ_MUL = 1;
    localparam int REQ_LD  = 2;

    typedef struct packed {
        logic              valid;
        logic [TAG_W-1:0]  tag;
        logic [DATA_W-1:0] data;
    } cdb_bcast_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational one-hot arbiter: round-robin from rr_ptr when CDB_RR_EN is
// defined, otherwise fixed priority with the lowest index winning.
module rr_arbiter
    import cdb_pkg::*;
#(
    parameter int NUM_REQ = 3,
    parameter int PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
`ifdef CDB_RR_EN
    input  logic [PTR_W-1:0]   rr_ptr,
`endif
    input  logic [NUM_REQ-1:0] eligible,
    output logic [NUM_REQ-1:0] grant
);

`ifdef CDB_RR_EN
    int idx;

    // Walk the search order backwards so the earliest eligible index wins.
    always_comb begin
        grant = '0;
        idx   = 0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = (int'(rr_ptr) + k) % NUM_REQ;
            if (eligible[idx]) begin
                grant      = '0;
                grant[idx] = 1'b1;
            end
        end
    end
`else
    // NOTE: grant gets a default before the loop so no latch is inferred.
    always_comb begin
        grant = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                grant    = '0;
                grant[i] = 1'b1;
            end
        end
    end
`endif

endmodule

// File: rtl/cdb_arbiter.sv
// Common Data Bus arbiter: grants one completing unit per cycle and registers
// its tag/result as the broadcast. Round-robin when CDB_RR_EN is defined.
module cdb_arbiter #(
    parameter int NUM_REQ = 3,
    parameter int TAG_W   = cdb_pkg::TAG_W,
    parameter int DATA_W  = cdb_pkg::DATA_W
) (
    input  logic                      Clock,
    input  logic                      Reset,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*TAG_W-1:0]  req_tag,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    input  logic                      flush,
    output logic [NUM_REQ-1:0]        grant,
    output logic                      cdb_valid,
    output logic [TAG_W-1:0]          cdb_tag,
    output logic [DATA_W-1:0]         cdb_data,
    output logic                      err_zero_tag
);
    import cdb_pkg::*;

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [NUM_REQ-1:0] tag_zero;
    logic [NUM_REQ-1:0] legal;
    logic [NUM_REQ-1:0] zero_req;
    logic [NUM_REQ-1:0] arb_in;
    logic               legal_any;
    logic [TAG_W-1:0]   win_tag;
    logic [DATA_W-1:0]  win_data;

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            tag_zero[i] = (req_tag[i*TAG_W +: TAG_W] == TAG_W'(TAG_NONE));
        end
    end

    // Tag-0 requesters are only consumed when no legal requester competes.
    assign legal     = (Reset || flush) ? '0 : (req & ~tag_zero);
    assign zero_req  = (Reset || flush) ? '0 : (req & tag_zero);
    assign legal_any = |legal;
    assign arb_in    = legal_any ? legal : zero_req;

`ifdef CDB_RR_EN
    logic [PTR_W-1:0] rr_ptr;
    logic [PTR_W-1:0] win_idx;

    always_comb begin
        win_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) win_idx = PTR_W'(i);
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            rr_ptr <= '0;
        end else if (legal_any) begin
            rr_ptr <= (win_idx == PTR_W'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
        end
    end
`endif

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_rr_arbiter (
`ifdef CDB_RR_EN
        .rr_ptr   (rr_ptr),
`endif
        .eligible (arb_in),
        .grant    (grant)
    );

    always_comb begin
        win_tag  = '0;
        win_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                win_tag  = req_tag[i*TAG_W +: TAG_W];
                win_data = req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            cdb_valid    <= 1'b0;
            cdb_tag      <= '0;
            cdb_data     <= '0;
            err_zero_tag <= 1'b0;
        end else begin
            cdb_valid <= legal_any;
            if (legal_any) begin
                cdb_tag  <= win_tag;
                cdb_data <= win_data;
            end
            if (|(req & tag_zero)) err_zero_tag <= 1'b1;
        end
    end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Self-checking bench for cdb_arbiter; expectations adapt to CDB_RR_EN.
module tb_cdb_arbiter;
    import cdb_pkg::*;

`ifdef CDB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic        Clock;
    logic        Reset;
    logic [2:0]  req;
    logic [23:0] req_tag;
    logic [47:0] req_data;
    logic        flush;
    logic [2:0]  grant;
    logic        cdb_valid;
    logic [7:0]  cdb_tag;
    logic [15:0] cdb_data;
    logic        err_zero_tag;

    int errors = 0;
    int checks = 0;

    // Reference model state
    int         m_ptr;
    cdb_bcast_t m_bc;
    logic       m_err;
    logic [2:0] exp_grant;
    int         exp_win;
    bit         exp_legal;

    cdb_arbiter #(.NUM_REQ(3), .TAG_W(8), .DATA_W(16)) dut (
        .Clock        (Clock),
        .Reset        (Reset),
        .req          (req),
        .req_tag      (req_tag),
        .req_data     (req_data),
        .flush        (flush),
        .grant        (grant),
        .cdb_valid    (cdb_valid),
        .cdb_tag      (cdb_tag),
        .cdb_data     (cdb_data),
        .err_zero_tag (err_zero_tag)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // Search the units in priority order (starting at the pointer when
    // round-robin); legal tags beat tag-0 requests, which are only drained.
    task automatic compute_expected();
        exp_grant = 3'b000;
        exp_legal = 1'b0;
        exp_win   = 0;
        if (!Reset && !flush) begin
            for (int k = 0; k < 3; k++) begin
                int i = (m_ptr + k) % 3;
                if (!exp_legal && req[i] && req_tag[i*8 +: 8] != 8'h00) begin
                    exp_legal = 1'b1;
                    exp_win   = i;
                end
            end
            if (exp_legal) begin
                exp_grant[exp_win] = 1'b1;
            end else begin
                for (int k = 2; k >= 0; k--) begin
                    int i = (m_ptr + k) % 3;
                    if (req[i]) begin
                        exp_grant    = 3'b000;
                        exp_grant[i] = 1'b1;
                    end
                end
            end
        end
    endtask

    task automatic drive(input logic [2:0] r, input logic [23:0] t,
                         input logic [47:0] d, input logic f, input logic rs);
        req = r; req_tag = t; req_data = d; flush = f; Reset = rs;
        #1;
        compute_expected();
    endtask

    task automatic tick();
        @(posedge Clock);
        if (Reset) begin
            m_ptr = 0;
            m_bc  = '0;
            m_err = 1'b0;
        end else begin
            if (exp_legal) begin
                m_bc.valid = 1'b1;
                m_bc.tag   = req_tag[exp_win*8 +: 8];
                m_bc.data  = req_data[exp_win*16 +: 16];
                if (RR) m_ptr = (exp_win + 1) % 3;
            end else begin
                m_bc.valid = 1'b0;
            end
            for (int i = 0; i < 3; i++)
                if (req[i] && req_tag[i*8 +: 8] == 8'h00) m_err = 1'b1;
        end
        #1;
        compute_expected();
    endtask

    task automatic apply_reset();
        drive(3'b000, '0, '0, 1'b0, 1'b1);
        tick();
        tick();
        drive(3'b000, '0, '0, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        drive(3'b111, {8'h03, 8'h02, 8'h01}, '0, 1'b0, 1'b1);
        checks++;
        if (grant !== 3'b000) begin errors++; $display("FAIL reset_grant got=%b exp=000", grant); end
        tick();
        checks++;
        if ({cdb_valid, cdb_tag, cdb_data, err_zero_tag} !== 26'd0) begin
            errors++;
            $display("FAIL reset_state got v=%b t=%h d=%h e=%b exp all zero", cdb_valid, cdb_tag, cdb_data, err_zero_tag);
        end
        drive(3'b000, '0, '0, 1'b0, 1'b0);
    endtask

    task automatic test_single();
        apply_reset();
        drive(3'b001, {16'h0, 8'h03}, {32'h0, 16'h00AA}, 1'b0, 1'b0);
        checks++;
        if (grant !== 3'b001) begin errors++; $display("FAIL single_grant got=%b exp=001", grant); end
        tick();
        drive(3'b000, '0, '0, 1'b0, 1'b0);
        checks++;
        if ({cdb_valid, cdb_tag, cdb_data} !== {1'b1, 8'h03, 16'h00AA}) begin
            errors++;
            $display("FAIL single_bcast got v=%b t=%h d=%h exp v=1 t=03 d=00aa", cdb_valid, cdb_tag, cdb_data);
        end
        tick();
        checks++;
        if (cdb_valid !== 1'b0 || cdb_tag !== 8'h03) begin
            errors++;
            $display("FAIL single_idle got v=%b t=%h exp v=0 t=03", cdb_valid, cdb_tag);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] seq [6];
        for (int c = 0; c < 6; c++) seq[c] = RR ? 8'((c % 3) + 1) : 8'h01;
        apply_reset();
        drive(3'b111, {8'h03, 8'h02, 8'h01}, {16'h3333, 16'h2222, 16'h1111}, 1'b0, 1'b0);
        for (int c = 0; c < 6; c++) begin
            tick();
            checks++;
            if (cdb_valid !== 1'b1 || cdb_tag !== seq[c]) begin
                errors++;
                $display("FAIL b2b_%0d got v=%b t=%h exp v=1 t=%h", c, cdb_valid, cdb_tag, seq[c]);
            end
        end
    endtask

    task automatic test_wrap();
        logic [2:0] g1;
        logic [2:0] g3;
        g1 = RR ? 3'b100 : 3'b001;
        g3 = RR ? 3'b010 : 3'b001;
        apply_reset();
        drive(3'b010, {8'h03, 8'h02, 8'h01}, '0, 1'b0, 1'b0);
        tick();
        drive(3'b101, {8'h03, 8'h02, 8'h01}, '0, 1'b0, 1'b0);
        checks++;
        if (grant !== g1) begin errors++; $display("FAIL wrap_grant1 got=%b exp=%b", grant, g1); end
        tick();
        drive(3'b101, {8'h03, 8'h02, 8'h01}, '0, 1'b0, 1'b0);
        checks++;
        if (grant !== 3'b001) begin errors++; $display("FAIL wrap_grant2 got=%b exp=001", grant); end
        tick();
        drive(3'b111, {8'h03, 8'h02, 8'h01}, '0, 1'b0, 1'b0);
        checks++;
        if (grant !== g3) begin errors++; $display("FAIL wrap_grant3 got=%b exp=%b", grant, g3); end
        tick();
    endtask

    task automatic test_flush();
        logic [2:0] gr;
        gr = RR ? 3'b010 : 3'b001;
        apply_reset();
        drive(3'b111, {8'h03, 8'h02, 8'h01}, '0, 1'b0, 1'b0);
        tick();
        drive(3'b111, {8'h03, 8'h02, 8'h01}, '0, 1'b1, 1'b0);
        checks++;
        if (grant !== 3'b000 || cdb_valid !== 1'b1) begin
            errors++;
            $display("FAIL flush_cycle got g=%b v=%b exp g=000 v=1", grant, cdb_valid);
        end
        tick();
        checks++;
        if (cdb_valid !== 1'b0) begin errors++; $display("FAIL flush_after got v=%b exp v=0", cdb_valid); end
        drive(3'b111, {8'h03, 8'h02, 8'h01}, '0, 1'b0, 1'b0);
        checks++;
        if (grant !== gr) begin errors++; $display("FAIL flush_resume got=%b exp=%b", grant, gr); end
        tick();
    endtask

    task automatic test_zero_tag();
        apply_reset();
        drive(3'b010, {8'h03, 8'h00, 8'h04}, {16'h0, 16'h0, 16'h0044}, 1'b0, 1'b0);
        checks++;
        if (grant !== 3'b010) begin errors++; $display("FAIL zero_grant got=%b exp=010", grant); end
        tick();
        checks++;
        if (err_zero_tag !== 1'b1 || cdb_valid !== 1'b0) begin
            errors++;
            $display("FAIL zero_flag got e=%b v=%b exp e=1 v=0", err_zero_tag, cdb_valid);
        end
        drive(3'b011, {8'h03, 8'h00, 8'h04}, {16'h0, 16'h0, 16'h0044}, 1'b0, 1'b0);
        checks++;
        if (grant !== 3'b001) begin errors++; $display("FAIL zero_legal_first got=%b exp=001", grant); end
        tick();
        checks++;
        if ({cdb_valid, cdb_tag, cdb_data, err_zero_tag} !== {1'b1, 8'h04, 16'h0044, 1'b1}) begin
            errors++;
            $display("FAIL zero_legal_bcast got v=%b t=%h d=%h e=%b exp v=1 t=04 d=0044 e=1", cdb_valid, cdb_tag, cdb_data, err_zero_tag);
        end
    endtask

    task automatic test_reset_mid();
        apply_reset();
        drive(3'b010, {8'h05, 8'h06, 8'h00}, '0, 1'b0, 1'b0);
        tick();
        drive(3'b100, {8'h05, 8'h06, 8'h00}, {16'h1234, 32'h0}, 1'b0, 1'b1);
        checks++;
        if (grant !== 3'b000) begin errors++; $display("FAIL rstmid_grant got=%b exp=000", grant); end
        tick();
        checks++;
        if (cdb_valid !== 1'b0) begin errors++; $display("FAIL rstmid_valid got=%b exp=0", cdb_valid); end
        drive(3'b110, {8'h05, 8'h06, 8'h00}, {16'h1234, 16'h5678, 16'h0}, 1'b0, 1'b0);
        checks++;
        if (grant !== 3'b010) begin errors++; $display("FAIL rstmid_ptr got=%b exp=010", grant); end
        tick();
        drive(3'b100, {8'h05, 8'h06, 8'h00}, {16'h1234, 32'h0}, 1'b0, 1'b0);
        checks++;
        if (grant !== 3'b100) begin errors++; $display("FAIL rstmid_repres got=%b exp=100", grant); end
        tick();
        checks++;
        if (cdb_valid !== 1'b1 || cdb_tag !== 8'h05 || cdb_data !== 16'h1234) begin
            errors++;
            $display("FAIL rstmid_bcast got v=%b t=%h d=%h exp v=1 t=05 d=1234", cdb_valid, cdb_tag, cdb_data);
        end
    endtask

    task automatic test_random();
        logic [2:0]  h_req;
        logic [23:0] h_tag;
        logic [47:0] h_data;
        logic        f;
        logic        rs;
        logic [2:0]  g;
        h_req = '0; h_tag = '0; h_data = '0;
        apply_reset();
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < 3; i++) begin
                if (!h_req[i] && $urandom_range(0, 1) == 1) begin
                    h_req[i] = 1'b1;
                    h_tag[i*8 +: 8] = ($urandom_range(0, 15) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
                    h_data[i*16 +: 16] = 16'($urandom);
                end
            end
            f  = ($urandom_range(0, 7) == 0);
            rs = ($urandom_range(0, 63) == 0);
            drive(h_req, h_tag, h_data, f, rs);
            checks++;
            if (grant !== exp_grant) begin
                errors++;
                $display("FAIL rand_grant cyc=%0d got=%b exp=%b", c, grant, exp_grant);
            end
            g = exp_grant;
            tick();
            checks++;
            if ({cdb_valid, cdb_tag, cdb_data, err_zero_tag} !== {m_bc, m_err}) begin
                errors++;
                $display("FAIL rand_bcast cyc=%0d got v=%b t=%h d=%h e=%b exp v=%b t=%h d=%h e=%b",
                         c, cdb_valid, cdb_tag, cdb_data, err_zero_tag, m_bc.valid, m_bc.tag, m_bc.data, m_err);
            end
            if (!rs) h_req = h_req & ~g;
        end
    endtask

    initial begin
        m_ptr = 0; m_bc = '0; m_err = 1'b0;
        test_reset();
        test_single();
        test_back_to_back();
        test_wrap();
        test_flush();
        test_zero_tag();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
